nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Multi-cycle controller that adds two WIDTH-bit operands by stepping them one 4-bit nibble per cycle through an external 4-bit carry-skip adder slice. It registers the inter-nibble carry and collects the partial sums into a full-width result. It sits directly upstream of the 4-bit slice: it drives the slice's A/B/cin and consumes its sum/carryOut. Valid/ready handshakes on both the operand side and the result side.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8. N = WIDTH/4 nibbles.

- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- in_valid  in  1  operand word valid
- in_ready  out  1  controller can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry into bit 0
- slc_a  out  4  nibble of A driven to the slice
- slc_b  out  4  nibble of B driven to the slice
- slc_cin  out  1  carry into the slice
- slc_sum  in  4  slice sum, combinational from slc_a/slc_b/slc_cin
- slc_cout  in  1  slice carryOut, combinational
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  A + B + cin, modulo 2^WIDTH
- out_cout  out  1  carry out of bit WIDTH-1
- out_ovf  out  1  two's-complement overflow

## Operation
- FSM states are IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch in_a, in_b and in_cin into a_reg, b_reg and carry_reg.
  - Clear idx and sum_reg, then go to RUN.
- RUN:
  - in_ready = 0.
  - slc_a = a_reg[4*idx+3 : 4*idx], slc_b = b_reg[4*idx+3 : 4*idx], slc_cin = carry_reg.
  - Each edge: sum_reg[4*idx+3 : 4*idx] <= slc_sum, carry_reg <= slc_cout, idx <= idx + 1.
  - On the edge where idx == N-1, go to DONE.
- DONE:
  - out_valid = 1.
  - out_sum = sum_reg, out_cout = carry_reg.
  - out_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (sum_reg[WIDTH-1] != a_reg[WIDTH-1]).
  - On out_valid & out_ready, go to IDLE.
- Outside RUN, slc_a, slc_b and slc_cin are 0.
- Outside DONE, out_valid is 0. The registered out_sum, out_cout and out_ovf hold their last values; they are only meaningful while out_valid = 1.
- idx width is clog2(N). It never wraps past N-1 because the FSM leaves RUN on that edge.
- Arithmetic is unsigned and modulo 2^WIDTH. cout and ovf are reported independently of each other.

## Timing
- Reset values: in_ready = 0 during the reset cycle and 1 afterwards (IDLE). out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, slc_* = 0, idx = 0.
- Accept edge T: RUN occupies cycles T+1 … T+N, with nibble k presented in cycle T+1+k. out_valid rises in cycle T+N+1.
- Latency from accept to out_valid is N+1 cycles (5 for WIDTH=16).
- Result backpressure:
  - out_sum, out_cout and out_ovf are stable while out_valid & !out_ready.
  - in_ready stays 0 until the result handshake has completed.
- After the result handshake on edge R, in_ready = 1 in cycle R+1. Minimum spacing between accepts is N+2 cycles.
- in_valid asserted outside IDLE is ignored; operands are not captured.
- rst_n low in any state, including mid-RUN or while holding in DONE:
  - Next state is IDLE and all registers take their reset values.
  - A partial result is never emitted.
- No combinational path from in_* to out_*. The only combinational paths are slc_sum/slc_cout feeding the registers.

## Test plan
- WIDTH=16, 0x1234 + 0x4321, cin=0 -> out_sum=0x5555, cout=0, ovf=0. out_valid rises exactly 5 cycles after accept; slc_a sequence is 4,3,2,1.
- 0xFFFF + 0x0001, cin=0 -> 0x0000, cout=1, ovf=0. Carry ripples through all nibbles; check slc_cin=1 for nibbles 1–3.
- 0x7FFF + 0x0000, cin=1 -> 0x8000, cout=0, ovf=1. Also 0x8000 + 0x8000, cin=0 -> 0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable and in_ready=0 throughout. in_valid pulsed during RUN/DONE is not captured. in_ready=1 one cycle after the handshake.
- Reset mid-RUN: drop rst_n during nibble 2 -> next cycle in IDLE with in_ready=1 and out_valid=0. The following transaction 0x0001 + 0x0001 yields 0x0002 and is not corrupted by the stale carry.
- Back-to-back: two operand words with out_ready tied 1 -> accepts exactly N+2 cycles apart, and both results are correct.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two WIDTH-bit operands one nibble per cycle through an external
// 4-bit adder slice. The inter-nibble carry lives in r_carry and the partial
// sums are collected in r_sum. Valid/ready handshakes on operand and result.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand word; in_ready high
// RUN   | presenting nibble r_idx to the slice, capturing its sum/carry
// DONE  | result held on out_*; waiting for out_ready

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       slc_a,
    output logic [3:0]       slc_b,
    output logic             slc_cin,
    input  logic [3:0]       slc_sum,
    input  logic             slc_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W+1:0] w_base;
    logic             w_last;

    // Bit offset of the current nibble and last-nibble flag.
    assign w_base = {r_idx, 2'b00};
    assign w_last = (r_idx == LAST_IDX);

    // Result outputs come straight from registers; nothing from in_* reaches them.
    assign out_sum  = r_sum;
    assign out_cout = r_carry;
    assign out_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_sum[WIDTH-1] != r_a[WIDTH-1]);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake/slice outputs.
    // in_ready is gated by rst_n so it reads 0 while reset is being applied.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        slc_a       = 4'h0;
        slc_b       = 4'h0;
        slc_cin     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                slc_a   = r_a[w_base +: 4];
                slc_b   = r_b[w_base +: 4];
                slc_cin = r_carry;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, nibble stepping and partial-sum collection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[w_base +: 4] <= slc_sum;
                    r_carry            <= slc_cout;
                    r_idx              <= w_last ? '0 : r_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: behavioural 4-bit slice, directed
// vectors, and a scoreboard queue drained by an independent result monitor.

module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic [3:0]       slc_a;
    logic [3:0]       slc_b;
    logic             slc_cin;
    logic [3:0]       slc_sum;
    logic             slc_cout;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .slc_a     (slc_a),
        .slc_b     (slc_b),
        .slc_cin   (slc_cin),
        .slc_sum   (slc_sum),
        .slc_cout  (slc_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // External 4-bit slice.
    assign {slc_cout, slc_sum} = 5'(slc_a) + 5'(slc_b) + 5'(slc_cin);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result monitor: compares every completed result handshake with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: result 0x%0h with nothing expected", out_sum);
            end else begin
                e = sb_q.pop_front();
                chk("sb_sum",  32'(out_sum),  32'(e.sum));
                chk("sb_cout", 32'(out_cout), 32'(e.cout));
                chk("sb_ovf",  32'(out_ovf),  32'(e.ovf));
            end
        end
    end

    // Waits (bounded) until in_ready is seen at a falling edge.
    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk(name, 32'(in_ready), 32'd1);
    endtask

    // One full transaction; called and returns just after a rising edge with the DUT idle.
    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                           input logic [WIDTH-1:0] e_sum, input logic e_cout, input logic e_ovf,
                           input int hold);
        logic       c;
        logic [4:0] t;
        logic [3:0] an;
        logic [3:0] bn;
        sb_q.push_back('{sum: e_sum, cout: e_cout, ovf: e_ovf});
        out_ready = (hold == 0);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_valid  = 1'b1;
        wait_ready("txn_accept_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
        c = cin;
        for (int k = 0; k < N; k++) begin
            if (k == 1) begin
                in_valid = 1'b1;
                in_a     = 16'hDEAD;
                in_b     = 16'hBEEF;
                in_cin   = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            an = a[4*k +: 4];
            bn = b[4*k +: 4];
            @(negedge clk);
            chk("run_slc_a",     32'(slc_a),     32'(an));
            chk("run_slc_b",     32'(slc_b),     32'(bn));
            chk("run_slc_cin",   32'(slc_cin),   32'(c));
            chk("run_out_valid", 32'(out_valid), 32'd0);
            chk("run_in_ready",  32'(in_ready),  32'd0);
            t = 5'(an) + 5'(bn) + 5'(c);
            c = t[4];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            chk("hold_sum",       32'(out_sum),   32'(e_sum));
            chk("hold_cout",      32'(out_cout),  32'(e_cout));
            chk("hold_ovf",       32'(out_ovf),   32'(e_ovf));
            @(posedge clk); #1;
            in_valid = (h == 0) && (h != hold - 1);
            in_a     = 16'h0F0F;
            in_b     = 16'h0F0F;
            if (h == hold - 1) out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_hs_in_ready",  32'(in_ready),  32'd1);
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("idle_slc_a",        32'(slc_a),     32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int n;

        // Reset behaviour.
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_cout",  32'(out_cout),  32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("rst_slc_a",     32'(slc_a),     32'd0);
        chk("rst_slc_cin",   32'(slc_cin),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed vectors.
        run_txn(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_txn(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
        run_txn(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 3);

        // Reset during nibble 2 of a carry-heavy add; nothing may be emitted.
        out_ready = 1'b1;
        in_a      = 16'hFFFF;
        in_b      = 16'h0001;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        wait_ready("abort_accept_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_nib2_slc_cin", 32'(slc_cin), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_slc_cin",   32'(slc_cin),   32'd0);
        chk("abort_out_sum",   32'(out_sum),   32'd0);
        chk("abort_out_cout",  32'(out_cout),  32'd0);
        @(posedge clk); #1;
        run_txn(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        sb_q.push_back('{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
        sb_q.push_back('{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
        in_a     = 16'hA5A5;
        in_b     = 16'h5A5A;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        wait_ready("b2b_first_timeout");
        t1 = cyc;
        @(posedge clk); #1;
        in_a   = 16'h4000;
        in_b   = 16'h4000;
        in_cin = 1'b0;
        wait_ready("b2b_second_timeout");
        t2 = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_accept_spacing", 32'(t2 - t1), 32'(N + 2));

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
